// File: rtl/alu_seq_ctrl.sv
// Instruction FIFO + 4x4 regfile sequencer around a combinational ALU; pop->capture->write-back in 3 cycles, in_ready drops when the FIFO is full.
// Optional registered carry/zero flags when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [8:0] in_instr,
  output logic       in_ready,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  output logic [2:0] alu_s,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [4:0] alu_result,
  output logic       done,
  output logic [4:0] out_result,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic       carry_flag,
  output logic       zero_flag
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e      state_q;
  logic [8:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]  regs_q [4];
  logic [1:0]  rd_q;
  logic [2:0]  alu_s_q;
  logic [3:0]  alu_a_q, alu_b_q;
  logic        done_q;
  logic [4:0]  out_result_q;
  logic        fifo_full, fifo_empty, push, pop;
  logic [8:0]  head;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_instr;
  end

  // Write-back is assigned last so it overrides a same-edge load to rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= 4'd0;
    end else begin
      if (ld_en)           regs_q[ld_addr] <= ld_data;
      if (state_q == WB)   regs_q[rd_q]    <= out_result_q[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_s_q      <= 3'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      rd_q         <= 2'd0;
      done_q       <= 1'b0;
      out_result_q <= 5'd0;
`ifdef ALU_SEQ_FLAGS_EN
      carry_flag   <= 1'b0;
      zero_flag    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            alu_s_q <= head[8:6];
            rd_q    <= head[5:4];
            alu_a_q <= regs_q[head[3:2]];
            alu_b_q <= regs_q[head[1:0]];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          out_result_q <= alu_result;
`ifdef ALU_SEQ_FLAGS_EN
          carry_flag   <= alu_result[4];
          zero_flag    <= (alu_result[3:0] == 4'd0);
`endif
          done_q  <= 1'b1;
          state_q <= WB;
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_s      = alu_s_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign done       = done_q;
  assign out_result = out_result_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU model driving alu_result.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [2:0] alu_s;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_result;
  logic       done;
  logic [4:0] out_result;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic       carry_flag, zero_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_EQ = 3'd2, OP_INC = 3'd3;

  alu_seq_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .done(done), .out_result(out_result),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
    , .carry_flag(carry_flag), .zero_flag(zero_flag)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_s)
      OP_ADD:  alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      OP_EQ:   alu_result = {4'd0, alu_a == alu_b};
      OP_INC:  alu_result = {1'b0, alu_a} + 5'd1;
      default: alu_result = 5'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic peek(input logic [1:0] a, output logic [3:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Push one instruction into an idle, empty block and check every stage.
  task automatic issue(input string tag, input logic [8:0] instr,
                       input logic [3:0] ea, input logic [3:0] eb, input logic [4:0] eres);
    logic [3:0] v;
    in_valid = 1'b1; in_instr = instr;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq({tag, "_s"}, alu_s, instr[8:6]);
    check_eq({tag, "_a"}, alu_a, ea);
    check_eq({tag, "_b"}, alu_b, eb);
    tick();
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_res"}, out_result, eres);
    tick();
    check_eq({tag, "_done_low"}, done, 0);
    peek(instr[5:4], v);
    check_eq({tag, "_wb"}, v, eres[3:0]);
  endtask

  initial begin
    logic [3:0] v;
    int ndone;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_alu_s", alu_s, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_out_result", out_result, 0);
    for (int i = 0; i < 4; i++) begin
      peek(i[1:0], v);
      check_eq("rst_reg", v, 0);
    end
`ifdef ALU_SEQ_FLAGS_EN
    check_eq("rst_carry", carry_flag, 0);
    check_eq("rst_zero", zero_flag, 0);
`endif

    load(2'd0, 4'd3);
    load(2'd1, 4'd5);
    issue("add", mk(OP_ADD, 2'd2, 2'd0, 2'd1), 4'd3, 4'd5, 5'd8);
    issue("sub", mk(OP_SUB, 2'd3, 2'd0, 2'd1), 4'd3, 4'd5, 5'b11110);
`ifdef ALU_SEQ_FLAGS_EN
    check_eq("sub_carry", carry_flag, 1);
    check_eq("sub_zero", zero_flag, 0);
`endif

    // Load to rd on the write-back edge loses to the write-back.
    in_valid = 1'b1; in_instr = mk(OP_ADD, 2'd3, 2'd0, 2'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("wbcol_res", out_result, 8);
    ld_en = 1'b1; ld_addr = 2'd3; ld_data = 4'd7;
    tick();
    ld_en = 1'b0;
    peek(2'd3, v);
    check_eq("wbcol_reg", v, 8);

    // Load to rs1 on the pop edge is not seen by the popped instruction.
    in_valid = 1'b1; in_instr = mk(OP_ADD, 2'd2, 2'd0, 2'd1);
    tick();
    in_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'd10;
    tick();
    ld_en = 1'b0;
    check_eq("popld_old_a", alu_a, 3);
    peek(2'd0, v);
    check_eq("popld_reg", v, 10);
    tick();
    check_eq("popld_res", out_result, 8);
    tick();

    // EQ then dependent INC, pushed back to back.
    load(2'd0, 4'd9);
    load(2'd1, 4'd9);
    in_valid = 1'b1; in_instr = mk(OP_EQ, 2'd2, 2'd0, 2'd1);
    tick();
    in_instr = mk(OP_INC, 2'd2, 2'd2, 2'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("eq_res", out_result, 1);
    tick();
    peek(2'd2, v);
    check_eq("eq_reg", v, 1);
    tick();
    check_eq("inc_s", alu_s, OP_INC);
    check_eq("inc_a", alu_a, 1);
    tick();
    check_eq("inc_done", done, 1);
    check_eq("inc_res", out_result, 2);
    tick();
    peek(2'd2, v);
    check_eq("inc_reg", v, 2);

    // Back-pressure: 8 push attempts, FIFO fills after 6, last two rejected.
    load(2'd3, 4'd0);
    ndone = 0;
    in_valid = 1'b1; in_instr = mk(OP_INC, 2'd3, 2'd3, 2'd0);
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (done) begin
        ndone++;
        check_eq("bp_gap", c, 3 * ndone);
        check_eq("bp_res", out_result, ndone);
      end
      if (c == 6) check_eq("bp_full", in_ready, 0);
      if (c == 7) check_eq("bp_full_hold", in_ready, 0);
      if (c == 8) begin
        check_eq("bp_ready_again", in_ready, 1);
        in_valid = 1'b0;
      end
    end
    check_eq("bp_count", ndone, 6);
    peek(2'd3, v);
    check_eq("bp_reg", v, 6);

    // Reset while EXEC with three instructions queued.
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    check_eq("prerst_a", alu_a, 7);
    rst = 1'b1;
    #1;
    check_eq("midrst_done", done, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_alu_s", alu_s, 0);
    check_eq("midrst_alu_a", alu_a, 0);
    check_eq("midrst_alu_b", alu_b, 0);
    check_eq("midrst_out_result", out_result, 0);
    for (int i = 0; i < 4; i++) begin
      peek(i[1:0], v);
      check_eq("midrst_reg", v, 0);
    end
    repeat (2) tick();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("postrst_no_done", ndone, 0);
    check_eq("postrst_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
